// File: rtl/priority_encoder16to4_if.sv
// Handshake bundle for priority_encoder16to4.
//   Input side : data_in[15:0], in_valid (to block), in_ready (from block)
//   Output side: data_out[3:0], out_valid, last (from block), out_ready (to block)
//   Optional   : count[4:0] (from block) when PRIORITY_ENCODER_COUNT_EN is defined
// Modports: slave = the encoder block, master = the producer/consumer driving it.
interface priority_encoder16to4_if;
  logic [15:0] data_in;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  data_out;
  logic        out_valid;
  logic        out_ready;
  logic        last;
`ifdef PRIORITY_ENCODER_COUNT_EN
  logic [4:0]  count;
`endif

  modport slave (
    input  data_in,
    input  in_valid,
    output in_ready,
    output data_out,
    output out_valid,
    input  out_ready,
`ifdef PRIORITY_ENCODER_COUNT_EN
    output count,
`endif
    output last
  );

  modport master (
    output data_in,
    output in_valid,
    input  in_ready,
    input  data_out,
    input  out_valid,
    output out_ready,
`ifdef PRIORITY_ENCODER_COUNT_EN
    input  count,
`endif
    input  last
  );
endinterface

// File: rtl/priority_encoder16to4.sv
// Serialising 16-to-4 priority encoder. Captures a 16-bit request vector and
// emits the index of every set bit, lowest first, one per output transfer.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - priority_encoder16to4_if.slave (input and output handshakes)
// Optional feature: define PRIORITY_ENCODER_COUNT_EN to add bus.count, the
// number of indices still pending (0..16).
module priority_encoder16to4 (
  input logic                   clk,
  input logic                   rst_n,
  priority_encoder16to4_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  state_e      state_q, state_d;
  logic [15:0] pending_q, pending_d;
  logic [3:0]  data_out_q, data_out_d;
  logic        last_q, last_d;
  logic        in_xfer, out_xfer;

  function automatic logic [3:0] lowest_idx(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

`ifdef PRIORITY_ENCODER_COUNT_EN
  logic [4:0] count_q, count_d;

  function automatic logic [4:0] popcount(input logic [15:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 16; i++) begin
      n = n + 5'(v[i]);
    end
    return n;
  endfunction
`endif

  assign in_xfer  = (state_q == StIdle) && bus.in_valid;
  assign out_xfer = (state_q == StEmit) && bus.out_ready;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
`ifdef PRIORITY_ENCODER_COUNT_EN
    count_d   = count_q;
`endif
    if (in_xfer) begin
      // A zero vector is loaded too, which simply leaves pending at zero.
      pending_d = bus.data_in;
      if (bus.data_in != 16'h0000) state_d = StEmit;
`ifdef PRIORITY_ENCODER_COUNT_EN
      count_d = popcount(bus.data_in);
`endif
    end else if (out_xfer) begin
      // Clear the lowest set bit.
      pending_d = pending_q & (pending_q - 16'd1);
      if (last_q) state_d = StIdle;
`ifdef PRIORITY_ENCODER_COUNT_EN
      count_d = count_q - 5'd1;
`endif
    end
    // Outputs are registered: precompute them from the next pending value.
    data_out_d = lowest_idx(pending_d);
    last_d     = (pending_d != 16'h0000) && ((pending_d & (pending_d - 16'd1)) == 16'h0000);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pending_q  <= 16'h0000;
      data_out_q <= 4'h0;
      last_q     <= 1'b0;
`ifdef PRIORITY_ENCODER_COUNT_EN
      count_q    <= 5'd0;
`endif
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      data_out_q <= data_out_d;
      last_q     <= last_d;
`ifdef PRIORITY_ENCODER_COUNT_EN
      count_q    <= count_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StEmit);
  assign bus.data_out  = data_out_q;
  assign bus.last      = last_q;
`ifdef PRIORITY_ENCODER_COUNT_EN
  assign bus.count     = count_q;
`endif

endmodule

// File: doc/priority_encoder16to4.md
PRIORITY_ENCODER16TO4 -- requirements
Module: priority_encoder16to4

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port clk, input, 1 bit: clock; all state SHALL update on the rising edge.
REQ-003 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port data_in, input, 16 bits: request vector; bit k set means index k is to be emitted.
REQ-005 Port in_valid, input, 1 bit: data_in is valid this cycle.
REQ-006 Port in_ready, output, 1 bit: the block accepts a vector this cycle.
REQ-007 Port data_out, output, 4 bits: binary index of the pending bit currently offered.
REQ-008 Port out_valid, output, 1 bit: data_out is valid.
REQ-009 Port out_ready, input, 1 bit: the consumer accepts data_out this cycle.
REQ-010 Port last, output, 1 bit: data_out is the final index of the captured vector; it is valid only while out_valid=1.

Function
REQ-011 The block SHALL have two states. In IDLE, in_ready=1 and out_valid=0. In EMIT, in_ready=0 and out_valid=1.
REQ-012 An input transfer SHALL occur at a rising edge with in_valid=1 and in_ready=1. That edge SHALL load data_in into a 16-bit pending register.
REQ-013 When a non-zero vector is accepted, the block SHALL enter EMIT at the same edge. out_valid SHALL be 1 in the next cycle (1-cycle latency).
REQ-014 When a zero vector is accepted, the block SHALL consume it silently and remain in IDLE. No output SHALL be produced, and in_ready SHALL stay 1.
REQ-015 In EMIT, data_out SHALL equal the index of the lowest set bit of the pending register (LSB-first priority).
REQ-016 In EMIT, last SHALL be 1 exactly when the pending register has one bit set.
REQ-017 An output transfer SHALL occur at a rising edge with out_valid=1 and out_ready=1. That edge SHALL clear the emitted bit in the pending register.
REQ-018 If the output transfer clears the final set bit, the block SHALL return to IDLE at that edge, and in_ready SHALL be 1 in the next cycle.
REQ-019 While out_valid=1 and out_ready=0, data_out and last SHALL remain stable, and the pending register SHALL not change.
REQ-020 While out_ready is held at 1, the block SHALL emit one index per cycle. A vector with N set bits SHALL occupy exactly N EMIT cycles.
REQ-021 Input and output SHALL never overlap: in_valid asserted during EMIT SHALL be ignored and no data SHALL be captured.
REQ-022 Vector 16'hFFFF SHALL emit indices 0 through 15 in order, with last=1 only on index 15.
REQ-023 A vector with only bit 15 set SHALL emit data_out=4'hF with last=1.

Reset
REQ-024 Asserting rst_n low SHALL immediately force the following, regardless of clk: state IDLE, pending register 16'h0000, data_out 4'h0, out_valid 0, last 0, in_ready 1.
REQ-025 Reset asserted in EMIT SHALL discard all unemitted indices. No partial output SHALL be emitted after reset.
REQ-026 After rst_n deasserts, the first input transfer SHALL be possible on the first rising edge.

Configuration
REQ-027 With macro PRIORITY_ENCODER_COUNT_EN defined, the block SHALL add output port count, 5 bits.
REQ-028 With PRIORITY_ENCODER_COUNT_EN defined, count SHALL hold the number of set bits in the pending register, range 0..16. It SHALL be registered, SHALL be 0 at reset and in IDLE, and SHALL decrement by 1 on each output transfer.
REQ-029 With PRIORITY_ENCODER_COUNT_EN undefined, the port count SHALL not exist and the popcount logic SHALL not exist. All other behaviour SHALL be identical.

Verification
REQ-030 Bench SHALL drive data_in=16'h8421, in_valid=1, out_ready=1 -> data_out 0,5,10,15 on consecutive cycles; last=1 only with 15; in_ready=1 the cycle after.
REQ-031 Bench SHALL drive data_in=16'h0000, in_valid=1 -> out_valid stays 0; in_ready stays 1; a following vector 16'h0002 is accepted next cycle and emits 1 with last=1.
REQ-032 Bench SHALL drive data_in=16'h0006, out_ready=0 for 3 cycles, then 1 -> data_out=1 stable for 3 cycles, then 1 and 2 emitted; in_valid with 16'hFFFF during EMIT is ignored.
REQ-033 Bench SHALL drive data_in=16'hFFFF, out_ready=1 -> 16 consecutive outputs 0..15; with PRIORITY_ENCODER_COUNT_EN, count reads 16,15,..,1, then 0.
REQ-034 Bench SHALL drive data_in=16'h00F0, assert rst_n=0 asynchronously mid-clock after 2 outputs -> out_valid, data_out and last drop to 0 immediately and in_ready=1; index 6 is never emitted.
